// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Access width for a func3 code; unused encodings behave as a full word.
    function automatic acc_size_e f3_size(input logic [2:0] func3);
        case (func3)
            F3_B, F3_BU: f3_size = SZ_BYTE;
            F3_H, F3_HU: f3_size = SZ_HALF;
            F3_W:        f3_size = SZ_WORD;
            default:     f3_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed lane and extend it according to the access size.
    always_comb begin
        byte_sel    = lanes[offset];
        half_sel    = offset[1] ? rdata[31:16] : rdata[15:0];
        is_unsigned = func3[2];
        case (f3_size(func3))
            SZ_BYTE: result = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: result = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack handshake, byte enables,
// load alignment/extension and pipeline stall generation.
// Optional build macro: MEM_TIMEOUT_EN (abort a BUSY access after TIMEOUT_CYC cycles).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_func3,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    mau_state_e            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [1:0]            lane_q, lane_d;
    logic [2:0]            func3_q, func3_d;
    logic [DATA_W-1:0]     load_data_q, load_data_d;

    logic                  req_active;
    logic                  req_is_write;
    acc_size_e             req_size;
    logic                  req_mis;
    logic [3:0]            byte_be;
    logic [3:0]            req_be;
    logic [DATA_W-1:0]     req_wdata_rep;
    logic [DATA_W-1:0]     ext_data;
    logic                  stall_c;
    logic                  mis_c;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                  bus_error_q, bus_error_d;
`else
    logic                  unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_be
            assign byte_be[gi] = (req_addr[1:0] == 2'(gi));
        end
    endgenerate

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .offset (lane_q),
        .func3  (func3_q),
        .result (ext_data)
    );

    // Decode the incoming request: size, alignment, enables and replicated store data.
    always_comb begin
        req_active   = req_read | req_write;
        req_is_write = req_write;
        req_size     = f3_size(req_func3);
        req_mis      = 1'b0;
        req_be       = BE_WORD;
        req_wdata_rep = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                req_be        = byte_be;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_mis       = req_addr[0];
                req_be        = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_mis       = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Next-state and handshake control; stall/misaligned are combinational.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        lane_d      = lane_q;
        func3_d     = func3_q;
        load_data_d = load_data_q;
        stall_c     = 1'b0;
        mis_c       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_error_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_active) begin
                    if (req_mis) begin
                        mis_c = 1'b1;
                    end else begin
                        stall_c     = 1'b1;
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_write;
                        mem_addr_d  = {req_addr[DM_ADDRESS-1:2], 2'b00};
                        mem_wdata_d = req_wdata_rep;
                        mem_be_d    = req_be;
                        lane_d      = req_addr[1:0];
                        func3_d     = req_func3;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        load_data_d = ext_data;
                    end
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    load_data_d = '0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                // Requests still reflect the completed instruction; let the pipeline advance.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            stall_c = 1'b0;
            mis_c   = 1'b0;
        end
    end

    // State and transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            lane_q      <= 2'b00;
            func3_q     <= 3'b000;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            lane_q      <= lane_d;
            func3_q     <= func3_d;
            load_data_q <= load_data_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Ack-timeout counter and the one-cycle bus error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end
    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

    assign stall      = stall_c;
    assign misaligned = mis_c;
    assign load_data  = load_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (timeout checks when MEM_TIMEOUT_EN is defined).
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        stall;
    logic [31:0] load_data;
    logic        misaligned, bus_error;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] ref_rdata;
    logic [1:0]  ref_off;
    logic [2:0]  ref_f3;
    logic [31:0] ref_res;

    int n_pass  = 0;
    int n_total = 0;

    int          acc_stall;
    logic        acc_berr, acc_req_seen, acc_unstable, acc_we;
    logic [8:0]  acc_addr;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_W      (32),
        .DM_ADDRESS  (9),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_func3  (req_func3),
        .stall      (stall),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    load_extend u_ref (
        .rdata  (ref_rdata),
        .offset (ref_off),
        .func3  (ref_f3),
        .result (ref_res)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: observed %h expected %h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access from its IDLE cycle (inputs already driven) to the
    // negedge of the DONE cycle; ack is driven in cycle ack_after (cycle 0 = IDLE).
    task automatic do_access(input string tag, input int ack_after, input logic [31:0] rd);
        bit done = 1'b0;
        acc_stall = 0; acc_berr = 1'b0; acc_req_seen = 1'b0; acc_unstable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mem_ack   = (c == ack_after);
            mem_rdata = (c == ack_after) ? rd : 32'h0;
            @(negedge clk);
            if (bus_error) acc_berr = 1'b1;
            if (mem_req) begin
                if (!acc_req_seen) begin
                    acc_addr = mem_addr; acc_be = mem_be; acc_wdata = mem_wdata; acc_we = mem_we;
                    acc_req_seen = 1'b1;
                end else if (mem_addr !== acc_addr || mem_be !== acc_be ||
                             mem_wdata !== acc_wdata || mem_we !== acc_we) begin
                    acc_unstable = 1'b1;
                end
            end
            if (!stall) begin
                done = 1'b1;
                break;
            end
            acc_stall++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        chk({tag, "_completes"}, 32'(done), 32'd1);
    endtask

    task automatic next_cycle_idle();
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic start(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [2:0] f3, input logic [31:0] wd);
        req_read = rd; req_write = wr; req_addr = a; req_func3 = f3; req_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        start(1'b1, 1'b0, 9'h006, F3_W, 32'h0);
        ref_rdata = 32'h0; ref_off = 2'd0; ref_f3 = F3_W;

        // Reset state, with a misaligned request present
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_read = 1'b0;

        // LW 0x010, ack 3 cycles after mem_req
        start(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        do_access("lw", 3, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(acc_stall), 32'd4);
        chk("lw_addr", 32'(acc_addr), 32'h010);
        chk("lw_be", 32'(acc_be), 32'hF);
        chk("lw_we", 32'(acc_we), 32'd0);
        chk("lw_stable", 32'(acc_unstable), 32'd0);
        chk("lw_done_req", 32'(mem_req), 32'd0);
        chk("lw_load_data", load_data, 32'hDEADBEEF);
        next_cycle_idle();

        // SB 0x013
        start(1'b0, 1'b1, 9'h013, F3_B, 32'h000000A5);
        do_access("sb", 1, 32'h11111111);
        chk("sb_stall_cycles", 32'(acc_stall), 32'd2);
        chk("sb_we", 32'(acc_we), 32'd1);
        chk("sb_addr", 32'(acc_addr), 32'h010);
        chk("sb_be", 32'(acc_be), 32'h8);
        chk("sb_wdata", acc_wdata, 32'hA5A5A5A5);
        chk("sb_load_kept", load_data, 32'hDEADBEEF);
        next_cycle_idle();

        // Read+write together at 0x012 as SH: write wins
        start(1'b1, 1'b1, 9'h012, F3_H, 32'h1234BEEF);
        do_access("sh", 2, 32'h22222222);
        chk("sh_stall_cycles", 32'(acc_stall), 32'd3);
        chk("sh_we", 32'(acc_we), 32'd1);
        chk("sh_be", 32'(acc_be), 32'hC);
        chk("sh_wdata", acc_wdata, 32'hBEEFBEEF);
        chk("sh_load_kept", load_data, 32'hDEADBEEF);
        next_cycle_idle();

        // LB / LBU at 0x011, LH / LHU at 0x012
        start(1'b1, 1'b0, 9'h011, F3_B, 32'h0);
        do_access("lb", 1, 32'h00008000);
        chk("lb_be", 32'(acc_be), 32'h2);
        chk("lb_data", load_data, 32'hFFFFFF80);
        next_cycle_idle();
        start(1'b1, 1'b0, 9'h011, F3_BU, 32'h0);
        do_access("lbu", 1, 32'h00008000);
        chk("lbu_data", load_data, 32'h00000080);
        next_cycle_idle();
        start(1'b1, 1'b0, 9'h012, F3_H, 32'h0);
        do_access("lh", 1, 32'h80000000);
        chk("lh_be", 32'(acc_be), 32'hC);
        chk("lh_data", load_data, 32'hFFFF8000);
        next_cycle_idle();
        start(1'b1, 1'b0, 9'h012, F3_HU, 32'h0);
        do_access("lhu", 1, 32'h80000000);
        chk("lhu_data", load_data, 32'h00008000);
        next_cycle_idle();

        // func3 011 acts as a word
        start(1'b1, 1'b0, 9'h010, 3'b011, 32'h0);
        do_access("f3_011", 1, 32'h0BADF00D);
        chk("f3_011_be", 32'(acc_be), 32'hF);
        chk("f3_011_data", load_data, 32'h0BADF00D);
        next_cycle_idle();

        // Misaligned LW 0x006 and LH 0x011
        start(1'b1, 1'b0, 9'h006, F3_W, 32'h0);
        @(negedge clk);
        chk("mis_lw_flag", 32'(misaligned), 32'd1);
        chk("mis_lw_stall", 32'(stall), 32'd0);
        chk("mis_lw_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_lw_req_later", 32'(mem_req), 32'd0);
        chk("mis_lw_load_kept", load_data, 32'h0BADF00D);
        @(posedge clk); #1;
        start(1'b1, 1'b0, 9'h011, F3_H, 32'h0);
        @(negedge clk);
        chk("mis_lh_flag", 32'(misaligned), 32'd1);
        next_cycle_idle();

        // Stray ack while IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stray_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_req", 32'(mem_req), 32'd0);
        chk("stray_ack_load", load_data, 32'h0BADF00D);
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        // No ack: 8 BUSY cycles, then bus_error pulse in DONE
        start(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        do_access("tmo", -1, 32'h0);
        chk("tmo_stall_cycles", 32'(acc_stall), 32'd9);
        chk("tmo_bus_error", 32'(acc_berr), 32'd1);
        chk("tmo_load_zero", load_data, 32'h0);
        chk("tmo_req_dropped", 32'(mem_req), 32'd0);
        next_cycle_idle();
        @(negedge clk);
        chk("tmo_pulse_once", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
`else
        // Long wait without timeout: bus_error stays low
        start(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        do_access("long", 12, 32'h55AA55AA);
        chk("long_stall_cycles", 32'(acc_stall), 32'd13);
        chk("long_no_bus_error", 32'(acc_berr), 32'd0);
        chk("long_data", load_data, 32'h55AA55AA);
        next_cycle_idle();
`endif

        start(1'b1, 1'b0, 9'h01C, F3_W, 32'h0);
        do_access("lw2", 1, 32'h13579BDF);
        chk("lw2_data", load_data, 32'h13579BDF);
        next_cycle_idle();

        // Reset during BUSY, ack arrives two cycles later
        start(1'b1, 1'b0, 9'h014, F3_W, 32'h0);
        @(negedge clk);
        chk("rb_idle_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_busy_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; req_read = 1'b0;
        @(negedge clk);
        chk("rb_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rb_req_dropped", 32'(mem_req), 32'd0);
        chk("rb_load_cleared", load_data, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rb_late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rb_late_ack_req", 32'(mem_req), 32'd0);
        chk("rb_late_ack_load", load_data, 32'h0);

        // Reference extender, hand-computed vectors
        ref_rdata = 32'h80007F81; ref_off = 2'd0; ref_f3 = F3_B; #1;
        chk("ext_lb_off0", ref_res, 32'hFFFFFF81);
        ref_rdata = 32'hAB000000; ref_off = 2'd3; ref_f3 = F3_BU; #1;
        chk("ext_lbu_off3", ref_res, 32'h000000AB);
        ref_rdata = 32'hFFFF0000; ref_off = 2'd2; ref_f3 = F3_HU; #1;
        chk("ext_lhu_off2", ref_res, 32'h0000FFFF);
        ref_rdata = 32'h00007FFF; ref_off = 2'd0; ref_f3 = F3_H; #1;
        chk("ext_lh_off0", ref_res, 32'h00007FFF);
        ref_rdata = 32'h89ABCDEF; ref_off = 2'd0; ref_f3 = 3'b111; #1;
        chk("ext_f3_111", ref_res, 32'h89ABCDEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and data memory, on the MEM stage.
- Turns the raw MemRead/MemWrite/func3/address request into a word-aligned memory transaction with byte enables, using a req/ack handshake, so memory can have variable latency.
- Stalls the whole pipeline while an access is outstanding.
- Returns load data that is already aligned and sign- or zero-extended, ready for the MEM/WB register.

Parameters:
- DATA_W, 32, data width (fixed at 32 for byte-enable logic).
- DM_ADDRESS, 9, byte address width.
- TIMEOUT_CYC, 64, cycles without ack before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_read  in  1  load request (EX/MEM MemRead)
- req_write  in  1  store request (EX/MEM MemWrite)
- req_addr  in  DM_ADDRESS  byte address (EX/MEM ALU result)
- req_wdata  in  DATA_W  store data, unaligned, in low bits
- req_func3  in  3  access size/sign
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert no bubble
- load_data  out  DATA_W  extended load result
- misaligned  out  1  current request misaligned, no access made
- bus_error  out  1  one-cycle timeout pulse (tied 0 without macro)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  DM_ADDRESS  word-aligned address ([1:0]=0)
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  DATA_W  read word, valid with mem_ack

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high, on clk.
  - Reset forces state IDLE and clears load_data, mem_req, mem_we, mem_be and bus_error.
  - stall and misaligned read 0 while reset is high.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Active request = req_read | req_write.
  - If both are set, the write wins and the read is ignored.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. misaligned=1 combinationally, stall=0, no mem_req, state stays IDLE, load_data unchanged.
  - An aligned request asserts stall=1 combinationally in the same cycle. On the next edge: mem_req=1, fields latched, go to BUSY.
- BUSY:
  - stall=1.
  - mem_req, mem_we, mem_addr, mem_wdata and mem_be hold stable until mem_ack.
  - On mem_ack: drop mem_req, register load_data (reads only; stores leave it unchanged), go to DONE.
- DONE:
  - stall=0 for exactly one cycle so the pipeline advances.
  - Request inputs are ignored, because they still show the completed instruction.
  - Go unconditionally to IDLE.
- Latency: aligned access with ack N cycles after mem_req rises stalls the pipeline for N+1 cycles. Minimum is 2 (ack in the first BUSY cycle).
- mem_ack outside BUSY is ignored.
- func3 handling (byte lane k = addr[1:0]):
  - 000 LB/SB: be=1<<k, wdata byte replicated x4, load byte k sign-extended.
  - 001 LH/SH: be=0011 (k=0) or 1100 (k=2), half replicated x2, load half sign-extended.
  - 010 LW/SW: be=1111.
  - 100 LBU: zero-extended byte k.
  - 101 LHU: zero-extended half.
  - 011/110/111: treated as word.
  - Stores with 100/101 are treated as SB/SH.
- Loads: mem_be is still driven and mem_we=0.
- Reset asserted in BUSY: abort, mem_req=0 after that edge. A late ack is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro: a $clog2(TIMEOUT_CYC+1)-bit counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC without ack: drop mem_req, pulse bus_error for one cycle, load_data=0, go to DONE.
  - Ack and timeout on the same cycle: ack wins.
- Without the macro: no counter, BUSY waits indefinitely, bus_error tied 0.

Decomposition:
- Package mem_access_pkg:
  - state enum mau_state_e {IDLE, BUSY, DONE}.
  - func3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Byte-enable constants.
- One sub-module: load_extend, combinational. Inputs: rdata, byte offset, func3. Output: extended result. Used both in-block and by the bench as a reference.

Test Plan:
- LW at 0x010, memory acks 3 cycles after mem_req, rdata 0xDEADBEEF -> stall high 4 cycles, mem_addr 0x010, be 1111, load_data 0xDEADBEEF in DONE.
- SB at 0x013, wdata 0x000000A5 -> mem_we=1, mem_addr 0x010, be 1000, mem_wdata 0xA5A5A5A5.
- LB at 0x011 and LBU at 0x011, rdata 0x00008000:
  - LB -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH at 0x012 with rdata 0x80000000 -> 0xFFFF8000.
- LW at 0x006 -> misaligned=1, stall=0, mem_req never rises.
- Reset asserted in BUSY, ack arrives 2 cycles later -> mem_req=0 after the reset edge, state IDLE, ack ignored, load_data 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=8, never ack -> bus_error pulses once after 8 BUSY cycles, load_data 0, stall falls in DONE.
